// File: rtl/fanout_pkg.sv
// Shared types and helpers for the fanout handshake: per-branch configuration and the
// ready-aggregation reduction used by both the fork and the ready aggregator.
package fanout_pkg;

  localparam int unsigned FANOUT_NUM_BRANCH_DEFAULT = 7;
  localparam int unsigned FANOUT_WIDTH_DEFAULT      = 17;
  localparam int unsigned FANOUT_MAX_BRANCH         = 32;

  typedef struct packed {
    logic en;
    logic sel;
  } fanout_cfg_t;

  // Callers zero-pad unused lanes; act=0 makes a lane's term 1, so padding never blocks.
  function automatic logic fanout_done(input logic [FANOUT_MAX_BRANCH-1:0] act,
                                       input logic [FANOUT_MAX_BRANCH-1:0] sent,
                                       input logic [FANOUT_MAX_BRANCH-1:0] ready);
    return &(~act | sent | ready);
  endfunction

endpackage

// File: rtl/fanout_branch_tracker.sv
// One downstream branch of the eager fork: remembers whether this branch already took
// the current token and presents its valid and its contribution to the retire reduction.
module fanout_branch_tracker
  import fanout_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  fanout_cfg_t i_cfg,
  input  logic        i_full,
  input  logic        i_retire,
  input  logic        i_ready,
  output logic        o_valid,
  output logic        o_term
);

  logic r_sent;
  logic w_act;

  assign w_act   = i_cfg.en & i_cfg.sel;
  assign o_valid = ~reset & i_full & w_act & ~r_sent;
  assign o_term  = fanout_done({{(FANOUT_MAX_BRANCH-1){1'b0}}, w_act},
                               {{(FANOUT_MAX_BRANCH-1){1'b0}}, r_sent},
                               {{(FANOUT_MAX_BRANCH-1){1'b0}}, i_ready});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sent <= 1'b0;
    end else if (i_retire) begin
      r_sent <= 1'b0;
    end else if (o_valid & i_ready) begin
      r_sent <= 1'b1;
    end
  end

endmodule

// File: rtl/fanout_eager_fork.sv
// Eager fork: registers one upstream token and broadcasts it to every enabled and selected
// branch, retiring it once all participating branches have accepted it.
module fanout_eager_fork
  import fanout_pkg::*;
#(
  parameter int unsigned NUM_BRANCH = FANOUT_NUM_BRANCH_DEFAULT,
  parameter int unsigned WIDTH      = FANOUT_WIDTH_DEFAULT,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [NUM_BRANCH-1:0] cfg_en,
  input  logic [NUM_BRANCH-1:0] cfg_sel,
  output logic [WIDTH-1:0]      data_out,
  output logic [NUM_BRANCH-1:0] valid_out,
  input  logic [NUM_BRANCH-1:0] ready_in,
  output logic [CNT_WIDTH-1:0]  stat_tokens
);

  logic                  r_full;
  logic [WIDTH-1:0]      r_data;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic [NUM_BRANCH-1:0] w_term;
  logic                  w_done;
  logic                  w_retire;
  logic                  w_accept;

  for (genvar gi = 0; gi < NUM_BRANCH; gi++) begin : g_branch
    fanout_cfg_t w_cfg;
    assign w_cfg = '{en: cfg_en[gi], sel: cfg_sel[gi]};

    fanout_branch_tracker u_tracker (
      .clk      (clk),
      .reset    (reset),
      .i_cfg    (w_cfg),
      .i_full   (r_full),
      .i_retire (w_retire),
      .i_ready  (ready_in[gi]),
      .o_valid  (valid_out[gi]),
      .o_term   (w_term[gi])
    );
  end

  assign w_done   = &w_term;
  assign w_retire = r_full & w_done;
  // Outputs are forced quiet while reset is high, even before the first reset edge.
  assign ready_out   = ~reset & (~r_full | w_done);
  assign w_accept    = valid_in & ready_out;
  assign data_out    = reset ? '0 : r_data;
  assign stat_tokens = reset ? '0 : r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_data <= data_in;
        r_full <= 1'b1;
      end else if (w_retire) begin
        r_full <= 1'b0;
      end
      if (w_retire) begin
        r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
